// File: rtl/ethernet_frame_unpadding_512.sv
// Strips Ethernet minimum-size padding from IPv4 frames on a 512-bit AXI-Stream path.
//
// The output frame length is cut to 14 + IPv4 total length when that is shorter than
// the received frame. All other frames pass through byte-identical. tdata is never
// modified. Only tkeep and tlast change on a trimmed frame.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_axis_*                 RX frames from the CMAC side (tvalid/tready/tdata/tkeep/tlast)
//   m_axis_*                 trimmed frames to the user side, one register stage
//   trim_count               number of frames shortened since reset (wraps)
module ethernet_frame_unpadding_512 (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic [31:0]  trim_count
);

  typedef enum logic [1:0] {StIdle, StCount, StThru, StDrop} state_e;

  state_e       state_q, state_d;
  logic [16:0]  rem_q, rem_d;
  logic [31:0]  trim_q, trim_d;
  logic         out_valid_q, out_valid_d;
  logic [511:0] out_data_q, out_data_d;
  logic [63:0]  out_keep_q, out_keep_d;
  logic         out_last_q, out_last_d;

  logic         s_fire;
  logic [15:0]  ethertype;
  logic [15:0]  total_len;
  logic [16:0]  frame_len;
  logic         is_ipv4;
  logic [16:0]  cur_rem;
  logic [6:0]   rem_bytes;
  logic [63:0]  rem_mask;
  logic         do_count;
  logic         emit;
  logic [63:0]  emit_keep;
  logic         emit_last;

  // Header fields are only meaningful on the first beat (StIdle).
  assign ethertype = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
  assign total_len = {s_axis_tdata[135:128], s_axis_tdata[143:136]};
  assign frame_len = 17'd14 + {1'b0, total_len};
  assign is_ipv4   = (ethertype == 16'h0800) && (total_len >= 16'd20);

  // Bytes still owed to the output, including the current beat.
  assign cur_rem   = (state_q == StIdle) ? frame_len : rem_q;
  assign rem_bytes = cur_rem[6:0];
  // First rem_bytes lanes set; only used when 1 <= cur_rem <= 64.
  assign rem_mask  = {64{1'b1}} >> (7'd64 - rem_bytes);

  // DROP sinks beats regardless of the output stage; reset forces ready low.
  assign s_axis_tready = aresetn &
                         ((state_q == StDrop) | ~out_valid_q | m_axis_tready);
  assign s_fire        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    trim_d      = trim_q;
    do_count    = 1'b0;
    emit        = 1'b0;
    emit_keep   = s_axis_tkeep;
    emit_last   = s_axis_tlast;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (s_fire) begin
      unique case (state_q)
        StIdle: begin
          if (is_ipv4) begin
            do_count = 1'b1;
          end else begin
            emit    = 1'b1;
            state_d = s_axis_tlast ? StIdle : StThru;
          end
        end
        StCount: do_count = 1'b1;
        StThru: begin
          emit = 1'b1;
          if (s_axis_tlast) state_d = StIdle;
        end
        StDrop: begin
          if (s_axis_tlast) state_d = StIdle;
        end
      endcase

      if (do_count) begin
        emit = 1'b1;
        if (cur_rem <= 17'd64) begin
          emit_keep = s_axis_tkeep & rem_mask;
          emit_last = 1'b1;
          rem_d     = '0;
          if (!s_axis_tlast) begin
            state_d = StDrop;
            trim_d  = trim_q + 32'd1;
          end else begin
            state_d = StIdle;
            // Last beat already ends the frame: only count if padding lanes were cut.
            if ((s_axis_tkeep & ~rem_mask) != '0) trim_d = trim_q + 32'd1;
          end
        end else if (s_axis_tlast) begin
          // Frame shorter than the IPv4 length claims: leave it alone.
          rem_d   = '0;
          state_d = StIdle;
        end else begin
          rem_d   = cur_rem - 17'd64;
          state_d = StCount;
        end
      end
    end

    // emit only happens when the output slot is free or draining this cycle.
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = s_axis_tdata;
      out_keep_d  = emit_keep;
      out_last_d  = emit_last;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      trim_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      trim_q      <= trim_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign trim_count    = trim_q;

endmodule

// File: doc/ethernet_frame_unpadding_512.md
ETHERNET_FRAME_UNPADDING_512 -- requirements
Module: ethernet_frame_unpadding_512

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: aclk and aresetn.
REQ-002 SHALL have the following ports (direction, width, meaning):
- aclk, in, 1: clock.
- aresetn, in, 1: async active-low reset.
- s_axis_tvalid, in, 1; s_axis_tready, out, 1; s_axis_tdata, in, 512; s_axis_tkeep, in, 64; s_axis_tlast, in, 1: RX frames from the CMAC side.
- m_axis_tvalid, out, 1; m_axis_tready, in, 1; m_axis_tdata, out, 512; m_axis_tkeep, out, 64; m_axis_tlast, out, 1: trimmed frames to the user side.
- trim_count, out, 32: number of frames shortened since reset.
REQ-003 SHALL map byte i to tdata[8i+7:8i] and tkeep[i]; byte 0 is the first wire byte.

Function
REQ-004 SHALL strip the Ethernet minimum-size padding from IPv4 frames, so that the output length is L = 14 + IPv4 total length.
REQ-005 SHALL parse the first beat of each frame:
- ethertype = {byte12, byte13}.
- total_len = {byte16, byte17}.
- L is computed as a 17-bit value.
REQ-006 SHALL trim a frame only if all of the following hold:
- ethertype == 0x0800;
- total_len >= 20;
- L is less than the actual input frame length.
Any other frame passes byte-identical to the output.
REQ-007 SHALL use the following states:
- IDLE: expecting the first beat.
- COUNT: IPv4 frame, bytes remaining is tracked.
- THRU: non-IPv4 or malformed frame, pass through until tlast.
- DROP: discard the rest of the frame.
REQ-008 Transitions on an accepted beat:
- IDLE, not IPv4 or total_len < 20: go to THRU, or stay in IDLE if tlast.
- IDLE/COUNT with rem = remaining bytes: out_keep = in_keep AND (first min(rem,64) bytes).
- If rem <= 64 and in tlast = 0: output tlast = 1, go to DROP, increment trim_count.
- If rem <= 64 and in tlast = 1: output tlast = 1, go to IDLE. Increment trim_count only if some in_keep bit was cleared.
- If rem > 64 and tlast = 1: input was shorter than L; pass the beat unchanged and go to IDLE.
- Otherwise: rem -= 64, stay in or enter COUNT.
- THRU: pass the beat; go to IDLE on tlast.
- DROP: s_axis_tready = 1, no output; go to IDLE on tlast.
REQ-009 SHALL register the output through a single stage, giving 1-cycle latency from input acceptance to m_axis_tvalid.
REQ-010 Outside DROP, s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready).
REQ-011 While m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL hold stable.
REQ-012 SHALL pass tdata unmodified; only tkeep and tlast are altered by trimming.
REQ-013 SHALL sustain one beat per cycle under continuous m_axis_tready = 1, with no bubbles between frames.
REQ-014 trim_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 A beat dropped in DROP SHALL NOT affect the output register or its contents.
REQ-016 A frame whose first beat has tlast = 1 and needs no trimming SHALL return to IDLE the same cycle.

Reset
REQ-017 While aresetn = 0, the block SHALL hold:
- m_axis_tvalid = 0;
- m_axis_tdata, m_axis_tkeep and m_axis_tlast = 0;
- state = IDLE;
- rem = 0;
- trim_count = 0;
- s_axis_tready = 0.
REQ-018 After aresetn deasserts, the next accepted beat SHALL be treated as a first beat. A partial frame interrupted by reset SHALL be discarded.

Verification
REQ-019 Single beat: IPv4 total_len = 28, keep all ones, tlast = 1 -> keep = 0x000003FFFFFFFFFF (42 bytes), tlast = 1, trim_count = 1.
REQ-020 Three-beat, 192B IPv4 frame with total_len = 86 (L = 100):
- beat 1: full keep;
- beat 2: keep = 36 ones, tlast = 1;
- beat 3: dropped;
- trim_count = 1.
REQ-021 ARP frame (ethertype 0x0806), 64B -> output identical, trim_count unchanged. 1514B IPv4 frame (24 beats) with matching total_len -> identical, trim_count unchanged.
REQ-022 Back-to-back 42B and 60B IPv4 frames with m_axis_tready toggling 1,0,0,1,… -> no loss or duplication, output stable while stalled, trim_count = 2.
REQ-023 aresetn pulsed low mid-way through a 3-beat frame, then a 42B IPv4 frame -> all outputs 0 during reset; the following frame is trimmed correctly with trim_count = 1.
